// File: rtl/xgmii_rs_link_fault_if.sv
// XGMII data/control bundle between the MAC side and the RS link-fault block.
// master: the MAC/PHY environment driving RX and MAC TX words.
// slave:  the RS block consuming RX/MAC TX and producing the TX words to the PHY.
interface xgmii_rs_link_fault_if;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [63:0] xgmii_txd_in;
    logic [7:0]  xgmii_txc_in;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;

    modport master (
        output xgmii_rxd, xgmii_rxc, xgmii_txd_in, xgmii_txc_in,
        input  xgmii_txd, xgmii_txc
    );

    modport slave (
        input  xgmii_rxd, xgmii_rxc, xgmii_txd_in, xgmii_txc_in,
        output xgmii_txd, xgmii_txc
    );
endinterface

// File: rtl/xgmii_rs_link_fault.sv
// MAC-side Reconciliation Sublayer link-fault block for 64-bit XGMII.
// RX: detects local/remote fault Sequence ordered sets (two columns per clock,
// column A then column B) and tracks link status. TX: overrides MAC data with
// remote-fault or idle words while faulted, switching only on idle words.
// Optional fault statistics counters: define XGMII_FAULT_STATS_EN.
module xgmii_rs_link_fault #(
    parameter int C_SEQ_THRESH = 4,
    parameter int C_CLEAR_COLS = 128
) (
    input  logic                        clk156,
    input  logic                        reset,
    xgmii_rs_link_fault_if.slave        xgmii,
    output logic [1:0]                  link_fault,
    output logic                        link_up,
    input  logic                        rs_ovr_disable,
    input  logic                        stat_clr,
    output logic [15:0]                 stat_local_cnt,
    output logic [15:0]                 stat_remote_cnt
);
    localparam int SEQ_W = $clog2(C_SEQ_THRESH + 1);
    localparam logic [1:0]  LF_OK     = 2'b00;
    localparam logic [1:0]  LF_LOCAL  = 2'b01;
    localparam logic [1:0]  LF_REMOTE = 2'b10;
    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
    localparam logic [63:0] RF_WORD   = 64'h0200009C_0200009C;

    typedef enum logic {TX_PASS, TX_FAULT} tx_state_t;

    // Classify one 32-bit column: LF_LOCAL/LF_REMOTE for a fault sequence, LF_OK otherwise.
    function automatic logic [1:0] col_type(input logic [31:0] d, input logic [3:0] c);
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01) return LF_LOCAL;
            if (d[31:24] == 8'h02) return LF_REMOTE;
        end
        return LF_OK;
    endfunction

    logic [1:0]       lf_q, lf_d;
    logic [1:0]       last_q, last_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [7:0]       col_q, col_d;
    logic [1:0]       col_t [2];
    tx_state_t        state_q, state_d;
    logic [63:0]      txd_q, txd_d;
    logic [7:0]       txc_q, txc_d;
    logic             tx_idle;

    assign col_t[0] = col_type(xgmii.xgmii_rxd[31:0],  xgmii.xgmii_rxc[3:0]);
    assign col_t[1] = col_type(xgmii.xgmii_rxd[63:32], xgmii.xgmii_rxc[7:4]);
    assign tx_idle  = (xgmii.xgmii_txc_in == 8'hFF) && (xgmii.xgmii_txd_in == IDLE_WORD);

    // Fault state machine: apply column A, then column B, to the registered state.
    always_comb begin
        lf_d   = lf_q;
        last_d = last_q;
        seq_d  = seq_q;
        col_d  = col_q;
        for (int i = 0; i < 2; i++) begin
            if (col_t[i] != LF_OK) begin
                if (col_t[i] == last_d) begin
                    if (seq_d < SEQ_W'(C_SEQ_THRESH)) seq_d = seq_d + 1'b1;
                end else begin
                    last_d = col_t[i];
                    seq_d  = SEQ_W'(1);
                end
                col_d = '0;
                if (seq_d == SEQ_W'(C_SEQ_THRESH)) lf_d = last_d;
            end else begin
                if (col_d < 8'(C_CLEAR_COLS)) col_d = col_d + 1'b1;
                if (col_d == 8'(C_CLEAR_COLS)) begin
                    seq_d = '0;
                    lf_d  = LF_OK;
                end
            end
        end
    end

    // RX fault-tracking state registers.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            lf_q   <= LF_LOCAL;
            last_q <= LF_LOCAL;
            seq_q  <= '0;
            col_q  <= '0;
        end else begin
            lf_q   <= lf_d;
            last_q <= last_d;
            seq_q  <= seq_d;
            col_q  <= col_d;
        end
    end

    // TX next state and output word; state changes only on an idle MAC word.
    always_comb begin
        state_d = state_q;
        txd_d   = IDLE_WORD;
        txc_d   = 8'hFF;
        case (state_q)
            TX_PASS: begin
                txd_d = xgmii.xgmii_txd_in;
                txc_d = xgmii.xgmii_txc_in;
                if (lf_q != LF_OK && !rs_ovr_disable && tx_idle) state_d = TX_FAULT;
            end
            default: begin
                if (lf_q == LF_LOCAL) begin
                    txd_d = RF_WORD;
                    txc_d = 8'h11;
                end
                if ((lf_q == LF_OK || rs_ovr_disable) && tx_idle) state_d = TX_PASS;
            end
        endcase
    end

    // TX state and registered output word.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q <= TX_FAULT;
            txd_q   <= IDLE_WORD;
            txc_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
        end
    end

    assign xgmii.xgmii_txd = txd_q;
    assign xgmii.xgmii_txc = txc_q;
    assign link_fault      = lf_q;
    assign link_up         = (lf_q == LF_OK);

`ifdef XGMII_FAULT_STATS_EN
    logic [15:0] loc_cnt_q, loc_cnt_d;
    logic [15:0] rem_cnt_q, rem_cnt_d;

    // Count entries into local/remote fault; clear wins over increment.
    always_comb begin
        loc_cnt_d = loc_cnt_q;
        rem_cnt_d = rem_cnt_q;
        if (lf_d == LF_LOCAL && lf_q != LF_LOCAL && loc_cnt_q != 16'hFFFF)
            loc_cnt_d = loc_cnt_q + 1'b1;
        if (lf_d == LF_REMOTE && lf_q != LF_REMOTE && rem_cnt_q != 16'hFFFF)
            rem_cnt_d = rem_cnt_q + 1'b1;
        if (stat_clr) begin
            loc_cnt_d = '0;
            rem_cnt_d = '0;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            loc_cnt_q <= '0;
            rem_cnt_q <= '0;
        end else begin
            loc_cnt_q <= loc_cnt_d;
            rem_cnt_q <= rem_cnt_d;
        end
    end

    assign stat_local_cnt  = loc_cnt_q;
    assign stat_remote_cnt = rem_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_local_cnt  = 16'h0000;
    assign stat_remote_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_xgmii_rs_link_fault.sv
// Directed testbench for xgmii_rs_link_fault.
module tb_xgmii_rs_link_fault;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] RF_W   = 64'h0200009C_0200009C;
    localparam logic [63:0] LSEQ_W = 64'h0100009C_0100009C;
    localparam logic [63:0] RSEQ_W = 64'h0200009C_0200009C;
    localparam logic [63:0] ALT_W  = 64'h0200009C_0100009C;
    localparam logic [63:0] DATA_W = 64'hDEADBEEF_01234567;

    logic        clk156 = 1'b0;
    logic        reset;
    logic [1:0]  link_fault;
    logic        link_up;
    logic        rs_ovr_disable;
    logic        stat_clr;
    logic [15:0] stat_local_cnt;
    logic [15:0] stat_remote_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    logic [63:0] frame_d [6];
    logic [7:0]  frame_c [6];

    xgmii_rs_link_fault_if bus ();

    xgmii_rs_link_fault dut (
        .clk156          (clk156),
        .reset           (reset),
        .xgmii           (bus),
        .link_fault      (link_fault),
        .link_up         (link_up),
        .rs_ovr_disable  (rs_ovr_disable),
        .stat_clr        (stat_clr),
        .stat_local_cnt  (stat_local_cnt),
        .stat_remote_cnt (stat_remote_cnt)
    );

    always #3 clk156 = ~clk156;

    task automatic tick;
        @(posedge clk156);
        #1;
    endtask

    task automatic set_rx(input logic [63:0] d, input logic [7:0] c);
        bus.xgmii_rxd = d;
        bus.xgmii_rxc = c;
    endtask

    task automatic set_tx(input logic [63:0] d, input logic [7:0] c);
        bus.xgmii_txd_in = d;
        bus.xgmii_txc_in = c;
    endtask

    // Idle RX until link reports OK (bounded), then two cycles so TX returns to pass-through.
    task automatic wait_link_ok;
        int k;
        k = 0;
        set_rx(IDLE_W, 8'hFF);
        set_tx(IDLE_W, 8'hFF);
        while (link_fault !== 2'b00 && k < 200) begin
            tick();
            k++;
        end
        n_vec++;
        if (link_fault !== 2'b00) begin
            $display("FAIL wait_link_ok timeout: link_fault=%b required 00", link_fault);
            n_err++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rs_ovr_disable = 1'b0;
        stat_clr = 1'b0;
        set_rx(IDLE_W, 8'hFF);
        set_tx(IDLE_W, 8'hFF);
        #2;
        n_vec++;
        if (link_fault !== 2'b01 || link_up !== 1'b0) begin
            $display("FAIL reset_status: link_fault=%b link_up=%b required 01/0", link_fault, link_up);
            n_err++;
        end
        tick();
        tick();
        n_vec++;
        if (bus.xgmii_txd !== IDLE_W || bus.xgmii_txc !== 8'hFF) begin
            $display("FAIL reset_tx: txd=%h txc=%h required %h/ff", bus.xgmii_txd, bus.xgmii_txc, IDLE_W);
            n_err++;
        end
        n_vec++;
        if (stat_local_cnt !== 16'd0 || stat_remote_cnt !== 16'd0) begin
            $display("FAIL reset_stats: local=%0d remote=%0d required 0/0", stat_local_cnt, stat_remote_cnt);
            n_err++;
        end
        reset = 1'b0;
    endtask

    task automatic test_link_up;
        for (int k = 1; k <= 63; k++) begin
            tick();
            n_vec++;
            if (link_fault !== 2'b01) begin
                $display("FAIL linkup_hold edge %0d: link_fault=%b required 01", k, link_fault);
                n_err++;
            end
        end
        n_vec++;
        if (bus.xgmii_txd !== RF_W || bus.xgmii_txc !== 8'h11) begin
            $display("FAIL linkup_rf63: txd=%h txc=%h required %h/11", bus.xgmii_txd, bus.xgmii_txc, RF_W);
            n_err++;
        end
        tick();
        n_vec++;
        if (link_fault !== 2'b00 || link_up !== 1'b1) begin
            $display("FAIL linkup_edge64: link_fault=%b link_up=%b required 00/1", link_fault, link_up);
            n_err++;
        end
        n_vec++;
        if (bus.xgmii_txd !== RF_W || bus.xgmii_txc !== 8'h11) begin
            $display("FAIL linkup_rf64: txd=%h txc=%h required %h/11", bus.xgmii_txd, bus.xgmii_txc, RF_W);
            n_err++;
        end
        tick();
        n_vec++;
        if (bus.xgmii_txd !== IDLE_W || bus.xgmii_txc !== 8'hFF) begin
            $display("FAIL linkup_idle65: txd=%h txc=%h required %h/ff", bus.xgmii_txd, bus.xgmii_txc, IDLE_W);
            n_err++;
        end
        set_tx(DATA_W, 8'h00);
        tick();
        n_vec++;
        if (bus.xgmii_txd !== DATA_W || bus.xgmii_txc !== 8'h00) begin
            $display("FAIL linkup_pass: txd=%h txc=%h required %h/00", bus.xgmii_txd, bus.xgmii_txc, DATA_W);
            n_err++;
        end
        set_tx(IDLE_W, 8'hFF);
    endtask

    task automatic test_local_fault;
        set_rx(LSEQ_W, 8'h11);
        tick();
        n_vec++;
        if (link_fault !== 2'b00) begin
            $display("FAIL local_seq2: link_fault=%b required 00", link_fault);
            n_err++;
        end
        tick();
        n_vec++;
        if (link_fault !== 2'b01 || link_up !== 1'b0) begin
            $display("FAIL local_seq4: link_fault=%b link_up=%b required 01/0", link_fault, link_up);
            n_err++;
        end
        set_rx(IDLE_W, 8'hFF);
        tick();
        n_vec++;
        if (bus.xgmii_txd !== IDLE_W || bus.xgmii_txc !== 8'hFF) begin
            $display("FAIL local_switch: txd=%h txc=%h required %h/ff", bus.xgmii_txd, bus.xgmii_txc, IDLE_W);
            n_err++;
        end
        tick();
        n_vec++;
        if (bus.xgmii_txd !== RF_W || bus.xgmii_txc !== 8'h11) begin
            $display("FAIL local_rf: txd=%h txc=%h required %h/11", bus.xgmii_txd, bus.xgmii_txc, RF_W);
            n_err++;
        end
        wait_link_ok();
    endtask

    task automatic test_remote_fault;
        set_rx(RSEQ_W, 8'h11);
        tick();
        n_vec++;
        if (link_fault !== 2'b00) begin
            $display("FAIL remote_seq2: link_fault=%b required 00", link_fault);
            n_err++;
        end
        tick();
        n_vec++;
        if (link_fault !== 2'b10) begin
            $display("FAIL remote_seq4: link_fault=%b required 10", link_fault);
            n_err++;
        end
        set_rx(IDLE_W, 8'hFF);
        tick();
        set_tx(DATA_W, 8'h00);
        tick();
        n_vec++;
        if (bus.xgmii_txd !== IDLE_W || bus.xgmii_txc !== 8'hFF) begin
            $display("FAIL remote_idle: txd=%h txc=%h required %h/ff", bus.xgmii_txd, bus.xgmii_txc, IDLE_W);
            n_err++;
        end
        wait_link_ok();
    endtask

    task automatic test_alternate;
        set_rx(ALT_W, 8'h11);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (link_fault !== 2'b00) begin
                $display("FAIL alternate cycle %0d: link_fault=%b required 00", k, link_fault);
                n_err++;
            end
        end
        set_rx(IDLE_W, 8'hFF);
        tick();
    endtask

    // Fault declared during a 6-word frame; ovr selects whether the override is disabled.
    task automatic test_frame(input logic ovr);
        rs_ovr_disable = ovr;
        set_rx(LSEQ_W, 8'h11);
        for (int k = 0; k < 6; k++) begin
            set_tx(frame_d[k], frame_c[k]);
            if (k == 2) set_rx(IDLE_W, 8'hFF);
            tick();
            n_vec++;
            if (bus.xgmii_txd !== frame_d[k] || bus.xgmii_txc !== frame_c[k]) begin
                $display("FAIL frame ovr=%0b word %0d: txd=%h txc=%h required %h/%h",
                         ovr, k, bus.xgmii_txd, bus.xgmii_txc, frame_d[k], frame_c[k]);
                n_err++;
            end
        end
        n_vec++;
        if (link_fault !== 2'b01) begin
            $display("FAIL frame ovr=%0b status: link_fault=%b required 01", ovr, link_fault);
            n_err++;
        end
        set_tx(IDLE_W, 8'hFF);
        tick();
        n_vec++;
        if (bus.xgmii_txd !== IDLE_W || bus.xgmii_txc !== 8'hFF) begin
            $display("FAIL frame ovr=%0b idle: txd=%h txc=%h required %h/ff", ovr, bus.xgmii_txd, bus.xgmii_txc, IDLE_W);
            n_err++;
        end
        if (ovr) set_tx(DATA_W, 8'h00);
        tick();
        n_vec++;
        if (!ovr && (bus.xgmii_txd !== RF_W || bus.xgmii_txc !== 8'h11)) begin
            $display("FAIL frame_override: txd=%h txc=%h required %h/11", bus.xgmii_txd, bus.xgmii_txc, RF_W);
            n_err++;
        end
        if (ovr && (bus.xgmii_txd !== DATA_W || bus.xgmii_txc !== 8'h00)) begin
            $display("FAIL frame_no_override: txd=%h txc=%h required %h/00", bus.xgmii_txd, bus.xgmii_txc, DATA_W);
            n_err++;
        end
        rs_ovr_disable = 1'b0;
        set_tx(IDLE_W, 8'hFF);
        tick();
        wait_link_ok();
    endtask

    task automatic test_stats;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
`ifdef XGMII_FAULT_STATS_EN
        exp_l = 16'd3;
        exp_r = 16'd1;
`else
        exp_l = 16'd0;
        exp_r = 16'd0;
`endif
        n_vec++;
        if (stat_local_cnt !== exp_l || stat_remote_cnt !== exp_r) begin
            $display("FAIL stats_count: local=%0d remote=%0d required %0d/%0d",
                     stat_local_cnt, stat_remote_cnt, exp_l, exp_r);
            n_err++;
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_vec++;
        if (stat_local_cnt !== 16'd0 || stat_remote_cnt !== 16'd0) begin
            $display("FAIL stats_clear: local=%0d remote=%0d required 0/0", stat_local_cnt, stat_remote_cnt);
            n_err++;
        end
    endtask

    task automatic test_midop_reset;
        set_rx(LSEQ_W, 8'h11);
        tick();
        tick();
        set_rx(IDLE_W, 8'hFF);
        tick();
        tick();
        n_vec++;
        if (bus.xgmii_txd !== RF_W || bus.xgmii_txc !== 8'h11) begin
            $display("FAIL midop_pre: txd=%h txc=%h required %h/11", bus.xgmii_txd, bus.xgmii_txc, RF_W);
            n_err++;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (bus.xgmii_txd !== IDLE_W || bus.xgmii_txc !== 8'hFF || link_fault !== 2'b01) begin
            $display("FAIL midop_reset: txd=%h txc=%h link_fault=%b required %h/ff/01",
                     bus.xgmii_txd, bus.xgmii_txc, link_fault, IDLE_W);
            n_err++;
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        frame_d[0] = 64'hD5555555_555555FB; frame_c[0] = 8'h01;
        frame_d[1] = 64'h11111111_22222222; frame_c[1] = 8'h00;
        frame_d[2] = 64'h33333333_44444444; frame_c[2] = 8'h00;
        frame_d[3] = 64'h55555555_66666666; frame_c[3] = 8'h00;
        frame_d[4] = 64'h77777777_88888888; frame_c[4] = 8'h00;
        frame_d[5] = 64'h070707FD_11223344; frame_c[5] = 8'hF0;
        test_reset();
        test_link_up();
        test_local_fault();
        test_remote_fault();
        test_alternate();
        test_frame(1'b0);
        test_frame(1'b1);
        test_stats();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
